// File: rtl/claw_game_ctrl.sv
// Claw-machine game sequencer: coin credits, game phase FSM and timer handshake.
// All outputs are registered from the state/arm registers, so they trail the state by one clk.
//
//   state     | meaning
//   ----------+------------------------------------------------
//   S_IDLE    | waiting for start with a credit available
//   S_PLAY    | player moves gantry, move-window timer T1 runs
//   S_DROP    | claw lowering, motion timer T2 runs
//   S_GRAB    | claw closing, motion timer T2 runs
//   S_LIFT    | claw rising, motion timer T2 runs
//   S_RELEASE | claw opening over the chute, motion timer T2 runs
module claw_game_ctrl #(
  parameter int MAX_CREDIT = 9,
  parameter int CW         = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          coin,
  input  logic          start,
  input  logic          drop,
  input  logic          Timeout1,
  input  logic          Timeout2,
  output logic          R_TR,
  output logic          En_T1,
  output logic          En_T2,
  output logic          move_en,
  output logic          claw_down,
  output logic          claw_close,
  output logic          claw_up,
  output logic          claw_open,
  output logic [CW-1:0] credits,
  output logic          busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PLAY,
    S_DROP,
    S_GRAB,
    S_LIFT,
    S_RELEASE
  } state_t;

  localparam logic [CW-1:0] LP_MAX = CW'(MAX_CREDIT);

  state_t        r_state;
  state_t        w_state_nxt;
  logic          r_arm;
  logic          w_arm_nxt;
  logic          r_coin_q;
  logic [CW-1:0] r_credits;
  logic [CW-1:0] w_cred_inc;
  logic [CW-1:0] w_cred_nxt;
  logic          w_coin_edge;
  logic          w_start_ok;
  logic          w_live;
  logic          w_motion;

  logic r_rtr, r_en_t1, r_en_t2, r_move, r_down, r_close, r_up, r_open, r_busy;

  assign w_coin_edge = coin & ~r_coin_q;
  assign w_start_ok  = (r_state == S_IDLE) & start & (r_credits != '0);
  assign w_motion    = (r_state == S_DROP) | (r_state == S_GRAB) |
                       (r_state == S_LIFT) | (r_state == S_RELEASE);

  // Saturate the coin first so coin+start at the limit nets MAX_CREDIT-1.
  assign w_cred_inc = (w_coin_edge && (r_credits < LP_MAX)) ? r_credits + CW'(1) : r_credits;
  assign w_cred_nxt = w_start_ok ? w_cred_inc - CW'(1) : w_cred_inc;

  // A timer is only trusted once its clear has gone out and its enable is visible.
  always_comb begin
    w_state_nxt = r_state;
    w_arm_nxt   = 1'b0;
    w_live      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_start_ok) begin
          w_state_nxt = S_PLAY;
          w_arm_nxt   = 1'b1;
        end
      end
      S_PLAY: begin
        w_live = ~r_arm & r_en_t1;
        if (w_live && (drop || Timeout1)) begin
          w_state_nxt = S_DROP;
          w_arm_nxt   = 1'b1;
        end
      end
      S_DROP: begin
        w_live = ~r_arm & r_en_t2;
        if (w_live && Timeout2) begin
          w_state_nxt = S_GRAB;
          w_arm_nxt   = 1'b1;
        end
      end
      S_GRAB: begin
        w_live = ~r_arm & r_en_t2;
        if (w_live && Timeout2) begin
          w_state_nxt = S_LIFT;
          w_arm_nxt   = 1'b1;
        end
      end
      S_LIFT: begin
        w_live = ~r_arm & r_en_t2;
        if (w_live && Timeout2) begin
          w_state_nxt = S_RELEASE;
          w_arm_nxt   = 1'b1;
        end
      end
      S_RELEASE: begin
        w_live = ~r_arm & r_en_t2;
        if (w_live && Timeout2) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_arm     <= 1'b0;
      r_coin_q  <= 1'b0;
      r_credits <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_arm     <= w_arm_nxt;
      r_coin_q  <= coin;
      r_credits <= w_cred_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rtr   <= 1'b0;
      r_en_t1 <= 1'b0;
      r_en_t2 <= 1'b0;
      r_move  <= 1'b0;
      r_down  <= 1'b0;
      r_close <= 1'b0;
      r_up    <= 1'b0;
      r_open  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_rtr   <= r_arm;
      r_en_t1 <= (r_state == S_PLAY) & ~r_arm;
      r_en_t2 <= w_motion & ~r_arm;
      r_move  <= (r_state == S_PLAY);
      r_down  <= (r_state == S_DROP);
      r_close <= (r_state == S_GRAB);
      r_up    <= (r_state == S_LIFT);
      r_open  <= (r_state == S_RELEASE);
      r_busy  <= (r_state != S_IDLE);
    end
  end

  assign R_TR       = r_rtr;
  assign En_T1      = r_en_t1;
  assign En_T2      = r_en_t2;
  assign move_en    = r_move;
  assign claw_down  = r_down;
  assign claw_close = r_close;
  assign claw_up    = r_up;
  assign claw_open  = r_open;
  assign credits    = r_credits;
  assign busy       = r_busy;

endmodule

// File: tb/tb_claw_game_ctrl.sv
// Bench for claw_game_ctrl: phase/age reference model, timer emulation, directed and random stimulus.
module tb_claw_game_ctrl;
  localparam int MAXC = 9;
  localparam int CW   = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic coin = 1'b0, start = 1'b0, drop = 1'b0;
  logic man_t1 = 1'b0, man_t2 = 1'b0, tmr_auto = 1'b1;
  logic tmr_t1 = 1'b0, tmr_t2 = 1'b0;
  logic Timeout1, Timeout2;
  logic R_TR, En_T1, En_T2, move_en, claw_down, claw_close, claw_up, claw_open, busy;
  logic [CW-1:0] credits;

  int total = 0;
  int bad   = 0;
  int cnt   = 0;
  int lim1  = 100;
  int lim2  = 2;

  assign Timeout1 = tmr_auto ? tmr_t1 : man_t1;
  assign Timeout2 = tmr_auto ? tmr_t2 : man_t2;

  always #5 clk = ~clk;

  claw_game_ctrl #(.MAX_CREDIT(MAXC), .CW(CW)) dut (
    .clk(clk), .rst(rst), .coin(coin), .start(start), .drop(drop),
    .Timeout1(Timeout1), .Timeout2(Timeout2),
    .R_TR(R_TR), .En_T1(En_T1), .En_T2(En_T2), .move_en(move_en),
    .claw_down(claw_down), .claw_close(claw_close), .claw_up(claw_up),
    .claw_open(claw_open), .credits(credits), .busy(busy)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", nm, act, expv, $time);
    end
  endtask

  // External timer: cleared by R_TR, counts enabled cycles, timeouts are held levels.
  always @(negedge clk or posedge rst) begin
    if (rst) cnt = 0;
    else if (R_TR) cnt = 0;
    else if (En_T1 || En_T2) cnt++;
    tmr_t1 = (cnt >= lim1);
    tmr_t2 = (cnt >= lim2);
  end

  // Reference model: phase 0..5 = idle, play, drop, grab, lift, release; age = clks since entry.
  int m_phase, m_age, m_cred, exp_cred;
  logic m_coin_q, m_edge, m_go, m_adv;
  logic [8:0] exp_o;

  function automatic logic [8:0] outs_of(input int ph, input int age);
    return {ph != 0 && age == 0, ph == 1 && age >= 1, ph >= 2 && age >= 1,
            ph == 1, ph == 2, ph == 3, ph == 4, ph == 5, ph != 0};
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_phase = 0; m_age = 0; m_cred = 0; m_coin_q = 1'b0;
      exp_o = '0; exp_cred = 0;
    end else begin
      exp_o    = outs_of(m_phase, m_age);
      m_edge   = coin && !m_coin_q;
      m_coin_q = coin;
      m_go     = (m_phase == 0) && start && (m_cred > 0);
      if (m_edge && m_cred < MAXC) m_cred++;
      if (m_go) m_cred--;
      exp_cred = m_cred;
      case (m_phase)
        0:       m_adv = m_go;
        1:       m_adv = (m_age >= 2) && (drop || Timeout1);
        default: m_adv = (m_age >= 2) && Timeout2;
      endcase
      if (m_adv) begin
        m_phase = (m_phase + 1) % 6;
        m_age   = 0;
      end else if (m_age < 3) begin
        m_age++;
      end
    end
  end

  logic prev_rtr = 1'b0;
  always @(negedge clk) begin
    chk("outputs", {R_TR, En_T1, En_T2, move_en, claw_down, claw_close, claw_up, claw_open, busy}, exp_o);
    chk("credits", 32'(credits), exp_cred);
    chk("en_overlap", En_T1 & En_T2, 0);
    chk("rtr_twice", R_TR & prev_rtr, 0);
    prev_rtr = R_TR;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic coin_pulse();
    coin = 1'b1; tick();
    coin = 1'b0; tick();
  endtask

  task automatic wait_idle(input int budget, input string nm);
    int n = 0;
    while (busy && n < budget) begin
      tick();
      n++;
    end
    chk(nm, busy, 0);
  endtask

  task automatic play_full(output int n_rtr, output logic [23:0] order, output int oh_bad);
    int n = 0;
    logic [3:0] code, last;
    bit seen = 0, coined = 0;
    n_rtr = 0; order = '0; last = '0; oh_bad = 0;
    start = 1'b1; tick(); start = 1'b0;
    while (n < 200) begin
      tick();
      n++;
      if (coin) coin = 1'b0;
      if (R_TR) n_rtr++;
      code = move_en ? 4'd1 : claw_down ? 4'd2 : claw_close ? 4'd3 :
             claw_up ? 4'd4 : claw_open ? 4'd5 : 4'd0;
      if ($countones({move_en, claw_down, claw_close, claw_up, claw_open}) > 1) oh_bad++;
      if (busy) seen = 1;
      if (seen && code != last) begin
        order = {order[19:0], code};
        last  = code;
      end
      if (claw_close && !coined) begin
        coin   = 1'b1;
        coined = 1;
      end
      if (seen && !busy) break;
    end
  endtask

  int nr, oh, n, seen_cnt;
  logic [23:0] ord;

  initial begin
    #1 rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    chk("rst_credits", 32'(credits), 0);
    chk("rst_outputs", {busy, R_TR, En_T1, En_T2, move_en}, 0);

    // three coins, then start
    repeat (3) coin_pulse();
    chk("coin3", 32'(credits), 3);
    start = 1'b1; tick(); start = 1'b0;
    chk("start_dec", 32'(credits), 2);
    chk("start_rtr0", R_TR, 0);
    tick();
    chk("play_arm", {R_TR, En_T1, busy}, 3'b101);
    tick();
    chk("play_en", {R_TR, En_T1, move_en, busy}, 4'b0111);

    // drop a few cycles into the window, long T1 so only drop can exit
    tick(); tick();
    drop = 1'b1; tick(); drop = 1'b0;
    chk("drop_edge", {En_T1, move_en, R_TR}, 3'b110);
    tick();
    chk("drop_enter", {claw_down, R_TR, En_T1, move_en}, 4'b1100);
    wait_idle(100, "game1_end");

    // full game ended by T1, coin inserted while grabbing
    lim1 = 3;
    play_full(nr, ord, oh);
    chk("full_rtr_count", nr, 5);
    chk("full_order", ord, 24'h123450);
    chk("full_onehot", oh, 0);
    chk("full_credits", 32'(credits), 2);

    // asynchronous reset while lifting
    start = 1'b1; tick(); start = 1'b0;
    n = 0;
    while (!claw_up && n < 100) begin
      tick();
      n++;
    end
    chk("lift_reached", claw_up, 1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst", {R_TR, En_T1, En_T2, move_en, claw_down, claw_close, claw_up, claw_open, busy, credits}, 0);
    tick();
    rst = 1'b0;
    tick();
    chk("post_rst", {busy, move_en, R_TR}, 0);

    // Timeout1 held through the arm cycle must not end the window
    tmr_auto = 1'b0; man_t1 = 1'b0; man_t2 = 1'b0;
    coin_pulse();
    man_t1 = 1'b1; start = 1'b1; tick(); start = 1'b0;
    tick(); tick();
    man_t1 = 1'b0;
    tick(); tick();
    chk("t1_arm_ignored", {move_en, claw_down}, 2'b10);
    man_t1 = 1'b1; tick(); man_t1 = 1'b0;
    lim1 = 100; lim2 = 2; tmr_auto = 1'b1;
    wait_idle(100, "t1_game_end");

    // saturation, then coin and start together at the limit
    repeat (12) coin_pulse();
    chk("sat9", 32'(credits), 9);
    coin = 1'b1; start = 1'b1; tick(); coin = 1'b0; start = 1'b0;
    chk("sat_start", 32'(credits), 8);
    wait_idle(200, "sat_game_end");

    // start without credit
    rst = 1'b1; tick(); rst = 1'b0; tick();
    seen_cnt = 0;
    start = 1'b1;
    repeat (6) begin
      tick();
      if (R_TR || busy) seen_cnt++;
    end
    start = 1'b0;
    chk("nocred_idle", seen_cnt, 0);
    chk("nocred_credits", 32'(credits), 0);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      tick();
      if (i % 250 == 0) begin
        tmr_auto = 1'($urandom % 2);
        lim1 = int'($urandom_range(1, 8));
        lim2 = int'($urandom_range(1, 4));
      end
      coin   = ($urandom % 4) == 0;
      start  = ($urandom % 6) == 0;
      drop   = ($urandom % 8) == 0;
      man_t1 = ($urandom % 5) == 0;
      man_t2 = ($urandom % 3) == 0;
      if ($urandom % 700 == 0) begin
        #2 rst = 1'b1;
        #1 rst = 1'b0;
      end
    end
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/claw_game_ctrl.md
Name: claw_game_ctrl

Overview:
- Top-level claw-machine sequencer: the master side of the timer interface.
- Issues timer clear (R_TR) and enables (En_T1, En_T2); consumes Timeout1 and Timeout2 to pace the game.
- Keeps a saturating coin-credit counter.
- Runs one game per credit: player move window, claw drop, grab, lift, release.

Parameters:
- MAX_CREDIT, 9, saturation limit of the credit counter (1..15).
- CW, 4, credit counter width.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst  input  1  asynchronous active-high reset.
- coin  input  1  coin sensor level; one rising edge = one credit.
- start  input  1  player start button level, sampled each clk.
- drop  input  1  player drop button level, sampled each clk.
- Timeout1  input  1  move-window timer expired.
- Timeout2  input  1  short motion timer expired.
- R_TR  output  1  timer clear pulse (one clk wide).
- En_T1  output  1  move-window timer enable.
- En_T2  output  1  motion timer enable.
- move_en  output  1  joystick/gantry enabled.
- claw_down  output  1  lower-claw motor.
- claw_close  output  1  close-claw motor.
- claw_up  output  1  raise-claw motor.
- claw_open  output  1  release-claw motor.
- credits  output  CW  current credit count.
- busy  output  1  game in progress (state != IDLE).

Behaviour:
- Reset (async, any time, mid-game included): state IDLE, arm=0, credits=0, coin edge register=0, all outputs 0.
- All outputs registered: state-derived outputs change 1 clk after the state register.
- Coin: rising edge detected against a registered copy of coin; +1 credit per edge, saturating at MAX_CREDIT. Further edges at saturation are dropped.
- States and transitions:
  - IDLE: start=1 and credits>0 -> PLAY, credits-1. start with credits=0 is ignored.
  - PLAY (move_en=1, timer T1): drop=1 or Timeout1 -> DROP.
  - DROP (claw_down=1, T2): Timeout2 -> GRAB.
  - GRAB (claw_close=1, T2): Timeout2 -> LIFT.
  - LIFT (claw_up=1, T2): Timeout2 -> RELEASE.
  - RELEASE (claw_open=1, T2): Timeout2 -> IDLE.
- Timer arming protocol (every timed-state entry):
  - Entry cycle: arm=1, R_TR=1, En_Tx=0.
  - Following cycles: arm=0, R_TR=0, En_Tx=1 until exit.
  - Timeouts and drop are ignored while arm=1, because the timer count is stale before the clear.
- En_T1 is high only in PLAY with arm=0. En_T2 is high only in DROP/GRAB/LIFT/RELEASE with arm=0. Both are never high together.
- R_TR is never high for two consecutive cycles; consecutive timed states each produce their own single pulse.
- Exit cycle: on the edge that moves to the next state, En drops to 0 and the new state's R_TR pulse follows.
- Simultaneous coin edge and game start in the same cycle: net credits unchanged (+1 -1). A coin edge at MAX_CREDIT together with start gives MAX_CREDIT-1.
- Simultaneous drop and Timeout1 in PLAY: single transition to DROP.
- Coin accepted in every state, including mid-game.
- start ignored outside IDLE. drop ignored outside PLAY.
- busy = (state != IDLE), registered.
- Timeout inputs are treated as levels. A timeout that stays high is not re-used, because the next state re-arms first.

Test Plan:
- Reset mid-LIFT: assert rst asynchronously -> all outputs 0 and credits=0 immediately, before the next clk edge; after release, state is IDLE.
- 3 coin pulses then start: credits 3 -> 2; next cycle R_TR=1, En_T1=0; the cycle after, En_T1=1, move_en=1, busy=1.
- Full game with timer model (Timeout2 after 2 enabled clks): exactly 5 R_TR pulses; phase order PLAY, DROP, GRAB, LIFT, RELEASE, IDLE; each motor output high only in its phase; En_T1 and En_T2 never overlap.
- drop pressed 4 cycles into PLAY: DROP entered next clk without waiting for Timeout1. A Timeout1 held high in the arm cycle of PLAY does not advance state.
- 12 coin edges with MAX_CREDIT=9 -> credits=9. Coin edge and start in the same cycle at credits=9 -> credits=8.
- start with credits=0 -> remains IDLE, R_TR never asserted. Coin inserted during GRAB -> credits increments, game flow unaffected.
